// File: rtl/otter_crypto_unit_if.sv
// Request/response bundle between the OTTER control unit and the crypto unit.
interface otter_crypto_unit_if;
   logic        CRYPTO_START;
   logic        CRYPTO_SEL;
   logic [31:0] CRYPTO_DATA;
   logic [31:0] CRYPTO_KEY;
   logic [31:0] CRYPTO_RESULT;
   logic        CRYPTO_BUSY;
   logic        CRYPTO_DONE;

   modport master (
      output CRYPTO_START, CRYPTO_SEL, CRYPTO_DATA, CRYPTO_KEY,
      input  CRYPTO_RESULT, CRYPTO_BUSY, CRYPTO_DONE
   );

   modport slave (
      input  CRYPTO_START, CRYPTO_SEL, CRYPTO_DATA, CRYPTO_KEY,
      output CRYPTO_RESULT, CRYPTO_BUSY, CRYPTO_DONE
   );
endinterface

// File: rtl/otter_crypto_unit.sv
// Iterative 32-bit Feistel encrypt/decrypt unit for the OTTER ENCRY instructions,
// one round per clock, result held until the next completion.
//
// state  | meaning
// S_IDLE | waiting for CRYPTO_START; operands latched on the accepting edge
// S_RUN  | one Feistel round per edge; last round writes RESULT and pulses DONE
module otter_crypto_unit #(
   parameter int ROUNDS = 8
) (
   input logic                CLK,
   input logic                RST,
   otter_crypto_unit_if.slave bus
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_RUN    = 1'b1;
   localparam logic [7:0] CNT_LAST = 8'(ROUNDS - 1);

   logic [0:0]  state_q;
   logic [15:0] l_q;
   logic [15:0] r_q;
   logic [31:0] key_q;
   logic        sel_q;
   logic [7:0]  cnt_q;
   logic [31:0] result_q;
   logic        done_q;

   logic [15:0] round_key;
   logic [15:0] f_in;
   logic [15:0] f_out;
   logic [15:0] l_nxt;
   logic [15:0] r_nxt;
   logic        last_round;

   // Decrypt walks the counter downward, so the round function input swaps halves.
   always_comb begin
      round_key  = (cnt_q[0] ? key_q[31:16] : key_q[15:0]) ^ {8'h00, cnt_q};
      f_in       = sel_q ? l_q : r_q;
      f_out      = {f_in[12:0], f_in[15:13]} ^ round_key;
      l_nxt      = r_q;
      r_nxt      = l_q ^ f_out;
      if (sel_q) begin
         l_nxt = r_q ^ f_out;
         r_nxt = l_q;
      end
      last_round = sel_q ? (cnt_q == 8'd0) : (cnt_q == CNT_LAST);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         l_q      <= 16'h0000;
         r_q      <= 16'h0000;
         key_q    <= 32'h0000_0000;
         sel_q    <= 1'b0;
         cnt_q    <= 8'd0;
         result_q <= 32'h0000_0000;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.CRYPTO_START) begin
                  l_q     <= bus.CRYPTO_DATA[31:16];
                  r_q     <= bus.CRYPTO_DATA[15:0];
                  key_q   <= bus.CRYPTO_KEY;
                  sel_q   <= bus.CRYPTO_SEL;
                  cnt_q   <= bus.CRYPTO_SEL ? CNT_LAST : 8'd0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               l_q <= l_nxt;
               r_q <= r_nxt;
               if (last_round) begin
                  result_q <= {l_nxt, r_nxt};
                  done_q   <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= sel_q ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.CRYPTO_RESULT = result_q;
   assign bus.CRYPTO_BUSY   = (state_q == S_RUN);
   assign bus.CRYPTO_DONE   = done_q;

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Self-checking bench for otter_crypto_unit: four instances with ROUNDS = 2, 8, 1, 255,
// a scoreboard of expected results, and a reference Feistel model.
module tb_otter_crypto_unit;

   typedef struct {
      int          d;
      logic [31:0] val;
   } sb_t;

   typedef struct {
      int          d;
      logic        s;
      logic [31:0] x;
      logic [31:0] k;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start_v [4];
   logic        sel_v   [4];
   logic [31:0] data_v  [4];
   logic [31:0] key_v   [4];
   logic [31:0] res_v   [4];
   logic        busy_v  [4];
   logic        done_v  [4];
   logic [31:0] last_res[4];
   int          done_cnt[4];

   sb_t sbq[$];
   int  checks;
   int  errors;

   otter_crypto_unit_if bus[4] ();

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         assign bus[g].CRYPTO_START = start_v[g];
         assign bus[g].CRYPTO_SEL   = sel_v[g];
         assign bus[g].CRYPTO_DATA  = data_v[g];
         assign bus[g].CRYPTO_KEY   = key_v[g];
         assign res_v[g]  = bus[g].CRYPTO_RESULT;
         assign busy_v[g] = bus[g].CRYPTO_BUSY;
         assign done_v[g] = bus[g].CRYPTO_DONE;
         otter_crypto_unit #(
            .ROUNDS(g == 0 ? 2 : (g == 1 ? 8 : (g == 2 ? 1 : 255)))
         ) u_dut (
            .CLK(clk),
            .RST(rst),
            .bus(bus[g])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rounds_of(input int d);
      case (d)
         0:       return 2;
         1:       return 8;
         2:       return 1;
         default: return 255;
      endcase
   endfunction

   function automatic logic [15:0] rotl3(input logic [15:0] v);
      return {v[12:0], v[15:13]};
   endfunction

   function automatic logic [31:0] model(input int rounds, input logic s,
                                         input logic [31:0] x, input logic [31:0] k);
      logic [15:0] l;
      logic [15:0] r;
      logic [15:0] kk;
      logic [15:0] t;
      int          i;
      logic [7:0]  i8;
      l = x[31:16];
      r = x[15:0];
      for (int j = 0; j < rounds; j++) begin
         i  = s ? (rounds - 1 - j) : j;
         i8 = i[7:0];
         kk = ((i % 2 == 0) ? k[15:0] : k[31:16]) ^ {8'h00, i8};
         if (!s) begin
            t = r;
            r = l ^ (rotl3(r) ^ kk);
            l = t;
         end else begin
            t = l;
            l = r ^ (rotl3(l) ^ kk);
            r = t;
         end
      end
      return {l, r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic monitor();
      sb_t e;
      for (int d = 0; d < 4; d++) begin
         if (!rst) begin
            if (done_v[d]) begin
               done_cnt[d]++;
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done dut%0d: got DONE with result 0x%08h, expected no DONE",
                           d, res_v[d]);
               end else begin
                  e = sbq.pop_front();
                  check($sformatf("result_dut%0d", d), res_v[d], e.val);
                  check($sformatf("done_source_dut%0d", d), d, e.d);
               end
            end else begin
               check($sformatf("hold_dut%0d", d), res_v[d], last_res[d]);
            end
            last_res[d] = res_v[d];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic run_op(input int d, input logic s, input logic [31:0] x,
                         input logic [31:0] k, input logic [31:0] exp,
                         output logic [31:0] res);
      int n;
      int busy_n;
      bit got;
      sb_t e;
      int r;
      r = rounds_of(d);
      start_v[d] = 1'b1;
      sel_v[d]   = s;
      data_v[d]  = x;
      key_v[d]   = k;
      e.d = d;
      e.val = exp;
      sbq.push_back(e);
      tick();
      busy_n = busy_v[d] ? 1 : 0;
      n = 0;
      got = 1'b0;
      // operands and START keep changing while busy; none of it may leak in
      while (!got && n < r + 4) begin
         data_v[d] = $urandom;
         key_v[d]  = $urandom;
         sel_v[d]  = ~s;
         tick();
         n++;
         if (done_v[d]) got = 1'b1;
         else if (busy_v[d]) busy_n++;
      end
      start_v[d] = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout dut%0d: got no DONE in %0d cycles, expected after %0d", d, n, r);
         if (sbq.size() > 0) void'(sbq.pop_back());
      end else begin
         check($sformatf("latency_dut%0d", d), n, r);
         check($sformatf("busy_cycles_dut%0d", d), busy_n, r);
         check($sformatf("busy_in_done_dut%0d", d), {31'b0, busy_v[d]}, 32'd0);
      end
      res = res_v[d];
   endtask

   vec_t        vt[4];
   logic [31:0] res;
   logic [31:0] res2;
   logic [31:0] x;
   logic [31:0] k;
   logic        s;
   int          rem;
   int          guard;
   int          dcnt;
   logic        exp_done;
   sb_t         e;

   initial begin
      checks = 0;
      errors = 0;
      for (int d = 0; d < 4; d++) begin
         start_v[d]  = 1'b0;
         sel_v[d]    = 1'b0;
         data_v[d]   = 32'h0;
         key_v[d]    = 32'h0;
         last_res[d] = 32'h0;
         done_cnt[d] = 0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("reset_result_dut%0d", d), res_v[d], 32'h0);
         check($sformatf("reset_busy_dut%0d", d), {31'b0, busy_v[d]}, 32'd0);
         check($sformatf("reset_done_dut%0d", d), {31'b0, done_v[d]}, 32'd0);
      end
      rst = 1'b0;
      tick();

      vt[0] = '{0, 1'b0, 32'h0001_0000, 32'h0, 32'h0001_0009};
      vt[1] = '{0, 1'b1, 32'h0001_0009, 32'h0, 32'h0001_0000};
      vt[2] = '{2, 1'b0, 32'h1234_5678, 32'h0, 32'h5678_A1F6};
      vt[3] = '{1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678,
                model(8, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678)};
      for (int v = 0; v < 4; v++) begin
         run_op(vt[v].d, vt[v].s, vt[v].x, vt[v].k, vt[v].exp, res);
         tick();
      end

      // round trip on ROUNDS=8 using the ciphertext the DUT just produced
      run_op(1, 1'b1, res, 32'h1234_5678, 32'hDEAD_BEEF, res2);
      tick();

      // asynchronous reset in the third RUN cycle abandons the operation
      dcnt = done_cnt[1];
      start_v[1] = 1'b1;
      data_v[1]  = 32'hCAFE_F00D;
      key_v[1]   = 32'h0BAD_1DEA;
      sel_v[1]   = 1'b0;
      tick();
      start_v[1] = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check("midreset_busy", {31'b0, busy_v[1]}, 32'd0);
      check("midreset_result", res_v[1], 32'h0);
      check("midreset_done", {31'b0, done_v[1]}, 32'd0);
      #1 rst = 1'b0;
      for (int d = 0; d < 4; d++) last_res[d] = 32'h0;
      repeat (12) tick();
      check("midreset_no_done", done_cnt[1], dcnt);

      // START held high with operands changing every cycle; timing follows a small model
      rem = 0;
      for (int c = 0; c < 45; c++) begin
         x = $urandom;
         k = $urandom;
         s = 1'($urandom_range(0, 1));
         start_v[1] = 1'b1;
         data_v[1]  = x;
         key_v[1]   = k;
         sel_v[1]   = s;
         exp_done   = 1'b0;
         if (rem == 0) begin
            e.d = 1;
            e.val = model(8, s, x, k);
            sbq.push_back(e);
            rem = 8;
         end else begin
            rem--;
            exp_done = (rem == 0);
         end
         tick();
         check("stream_done", {31'b0, done_v[1]}, {31'b0, exp_done});
      end
      start_v[1] = 1'b0;
      guard = 0;
      while (sbq.size() > 0 && guard < 30) begin
         tick();
         guard++;
      end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL stream_drain: got %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
      tick();

      // randomized round trips at the extreme round counts
      for (int t = 0; t < 1000; t++) begin
         x = $urandom;
         k = $urandom;
         run_op(2, 1'b0, x, k, model(1, 1'b0, x, k), res);
         run_op(2, 1'b1, res, k, x, res2);
      end
      for (int t = 0; t < 40; t++) begin
         x = $urandom;
         k = $urandom;
         run_op(3, 1'b0, x, k, model(255, 1'b0, x, k), res);
         tick();
         run_op(3, 1'b1, res, k, x, res2);
      end
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
